piso_bit_serializer: RTL and testbench

//   Parallel-in/serial-out stage directly upstream of the 1001 sequence detector.

---
 rtl/serial_link_pkg.sv | 12 +
 rtl/piso_bit_serializer.sv | 107 ++++++++++
 tb/tb_piso_bit_serializer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared state encoding and default width for the serial link
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } ser_state_e;

    localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - word-to-bitstream serializer feeding the 1001 detector
// Optional trailing even-parity bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_bit_serializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEF,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_e     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           last_bit;
    logic           accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic           parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
    assign accept   = data_valid && data_ready;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        data_ready = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: data_ready = 1'b1;
            ST_SHIFT: begin
                shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    bit_cnt_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_d    = ST_PARITY;
`else
                    state_d    = ST_IDLE;
                    data_ready = 1'b1;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                data_ready = 1'b1;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // An accept on the final cycle of a word chains straight into the next one.
        if (accept) begin
            state_d   = ST_SHIFT;
            shreg_d   = data_in;
            bit_cnt_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_d  = ^data_in;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign ser_valid = (state_q != ST_IDLE);

`ifdef PISO_SERIALIZER_PARITY_EN
    assign word_done = (state_q == ST_PARITY);
    assign ser_out   = (state_q == ST_SHIFT)  ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) :
                       (state_q == ST_PARITY) ? parity_q : 1'b0;
`else
    assign word_done = last_bit;
    assign ser_out   = (state_q == ST_SHIFT) ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) : 1'b0;
`endif

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - directed self-checking bench for piso_bit_serializer
module tb_piso_bit_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 8 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, m_ser, m_sv, m_busy, m_done;
    logic       l_ready, l_ser, l_sv, l_busy, l_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .data_in(m_data), .data_valid(m_valid),
        .data_ready(m_ready), .ser_out(m_ser), .ser_valid(m_sv),
        .busy(m_busy), .word_done(m_done)
    );

    piso_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .data_in(l_data), .data_valid(l_valid),
        .data_ready(l_ready), .ser_out(l_ser), .ser_valid(l_sv),
        .busy(l_busy), .word_done(l_done)
    );

    typedef struct {
        logic       lsb;
        logic [7:0] word;
        logic [7:0] bits;   // emission order, leftmost first
        logic       par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic so, sv, wd, by;
        if (v.lsb) begin l_data = v.word; l_valid = 1'b1; end
        else       begin m_data = v.word; m_valid = 1'b1; end
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        l_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            so = v.lsb ? l_ser  : m_ser;
            sv = v.lsb ? l_sv   : m_sv;
            wd = v.lsb ? l_done : m_done;
            chk("vec_ser_valid", {31'd0, sv}, 32'd1);
            chk("vec_ser_out", {31'd0, so}, {31'd0, (i < 8) ? v.bits[7-i] : v.par});
            chk("vec_word_done", {31'd0, wd}, {31'd0, (i == NB - 1)});
        end
        @(negedge clk);
        sv = v.lsb ? l_sv : m_sv;
        by = v.lsb ? l_busy : m_busy;
        chk("vec_idle_valid", {31'd0, sv}, 32'd0);
        chk("vec_idle_busy", {31'd0, by}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] s;
        vecs[0] = '{1'b0, 8'h9A, 8'b10011010, 1'b0};
        vecs[1] = '{1'b0, 8'h07, 8'b00000111, 1'b1};
        vecs[2] = '{1'b0, 8'h80, 8'b10000000, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 8'b10000000, 1'b1};
        vecs[4] = '{1'b1, 8'h09, 8'b10010000, 1'b0};
        vecs[5] = '{1'b1, 8'h9A, 8'b01011001, 1'b0};

        rst = 1'b1; m_valid = 1'b0; l_valid = 1'b0; m_data = '0; l_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ser_valid", {31'd0, m_sv}, 32'd0);
        chk("rst_ser_out", {31'd0, m_ser}, 32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_word_done", {31'd0, m_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Back-to-back words with data_valid held high: no gap between them.
`ifdef PISO_SERIALIZER_PARITY_EN
        s = 18'b10100101_0_00111100_0;
`else
        s = {16'b10100101_00111100, 2'b00};
`endif
        @(negedge clk);
        m_data = 8'hA5; m_valid = 1'b1;
        chk("b2b_idle_ready", {31'd0, m_ready}, 32'd1);
        @(posedge clk);
        #1;
        m_data = 8'h3C;
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            chk("b2b_ser_valid", {31'd0, m_sv}, 32'd1);
            chk("b2b_ser_out", {31'd0, m_ser}, {31'd0, s[17-i]});
            chk("b2b_ready", {31'd0, m_ready}, {31'd0, (i == NB - 1) || (i == 2 * NB - 1)});
            chk("b2b_word_done", {31'd0, m_done}, {31'd0, (i == NB - 1) || (i == 2 * NB - 1)});
            if (i == NB) m_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, m_busy}, 32'd0);

        // Backpressure: a word offered mid-shift is ignored.
        @(negedge clk);
        m_data = 8'hC3; m_valid = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        s = {8'b11000011, 1'b0, 9'd0};
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            chk("bp_ser_out", {31'd0, m_ser}, {31'd0, s[17-i]});
            if (i == 3) begin
                chk("bp_ready_low", {31'd0, m_ready}, 32'd0);
                m_data = 8'hFF; m_valid = 1'b1;
            end
            if (i == 4) m_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_idle_valid", {31'd0, m_sv}, 32'd0);
        chk("bp_idle_busy", {31'd0, m_busy}, 32'd0);

        // Reset after the fourth bit of 8'hFF drops the word.
        m_data = 8'hFF; m_valid = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rm_ser_out", {31'd0, m_ser}, 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rm_ser_valid", {31'd0, m_sv}, 32'd0);
        chk("rm_ser_out0", {31'd0, m_ser}, 32'd0);
        chk("rm_busy", {31'd0, m_busy}, 32'd0);
        chk("rm_word_done", {31'd0, m_done}, 32'd0);
        chk("rm_ready", {31'd0, m_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_after_valid", {31'd0, m_sv}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
